// File: rtl/sram_image_loader.sv
// Packs a 1-bit/beat pixel stream into one 16-bit word per row and writes
// nrows, ncols and the row words to SRAM. Optional trailer: LOADER_TERMINATOR_EN.
module sram_image_loader #(
   parameter logic [11:0] BASE_ADDR  = 12'h000,
   parameter int unsigned MAX_ROWS   = 16,
   parameter logic [15:0] TERMINATOR = 16'h00FF
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        load_start,
   input  logic [15:0] load_nrows,
   input  logic [15:0] load_ncols,
   input  logic        load_abort,
   input  logic        pix_valid,
   input  logic        pix_data,
   output logic        pix_ready,
   output logic        loader_busy,
   output logic        load_done,
   output logic        load_error,
   output logic [11:0] dut_sram_write_address,
   output logic [15:0] dut_sram_write_data,
   output logic        dut_sram_write_enable
);

   typedef enum logic [2:0] {
      StIdle,
      StHdrR,
      StHdrC,
      StFill,
      StRowWr,
`ifdef LOADER_TERMINATOR_EN
      StTerm,
`endif
      StFin
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] nrows_q, nrows_d;
   logic [15:0] ncols_q, ncols_d;
   logic [3:0]  col_q, col_d;
   logic [15:0] row_q, row_d;
   logic [15:0] pack_q, pack_d;
   logic        we_q, we_d;
   logic [11:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        err_q, err_d;

   logic        dims_ok;
   logic        last_col;
   logic        last_row;
   logic        busy;

`ifndef LOADER_TERMINATOR_EN
   logic unused_term;
   assign unused_term = ^TERMINATOR;
`endif

   assign dims_ok  = (load_nrows != 16'd0) && (32'(load_nrows) <= MAX_ROWS) &&
                     (load_ncols != 16'd0) && (load_ncols <= 16'd16);
   assign last_col = ({1'b0, col_q} == (ncols_q[4:0] - 5'd1));
   assign last_row = (row_q == (nrows_q - 16'd1));
   assign busy     = (state_q != StIdle) && (state_q != StFin);

   assign pix_ready              = (state_q == StFill);
   assign loader_busy            = busy;
   assign load_done              = (state_q == StFin);
   assign load_error             = err_q;
   assign dut_sram_write_address = addr_q;
   assign dut_sram_write_data    = data_q;
   assign dut_sram_write_enable  = we_q;

   // Write strobe/address/data are registered on entry to the writing state,
   // so the enable is visible during HDR_R, HDR_C, ROW_WR and TERM.
   always_comb begin
      state_d = state_q;
      nrows_d = nrows_q;
      ncols_d = ncols_q;
      col_d   = col_q;
      row_d   = row_q;
      pack_d  = pack_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = 1'b0;

      if (load_abort && busy) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (load_start) begin
                  if (dims_ok) begin
                     nrows_d = load_nrows;
                     ncols_d = load_ncols;
                     col_d   = 4'd0;
                     row_d   = 16'd0;
                     pack_d  = 16'd0;
                     state_d = StHdrR;
                     we_d    = 1'b1;
                     addr_d  = BASE_ADDR;
                     data_d  = load_nrows;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            StHdrR: begin
               state_d = StHdrC;
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + 12'd1;
               data_d  = ncols_q;
            end
            StHdrC: begin
               state_d = StFill;
            end
            StFill: begin
               if (pix_valid) begin
                  pack_d[col_q] = pix_data;
                  if (last_col) begin
                     col_d   = 4'd0;
                     state_d = StRowWr;
                     we_d    = 1'b1;
                     addr_d  = BASE_ADDR + 12'd2 + row_q[11:0];
                     data_d  = pack_d;
                  end else begin
                     col_d = col_q + 4'd1;
                  end
               end
            end
            StRowWr: begin
               pack_d = 16'd0;
               row_d  = row_q + 16'd1;
               if (last_row) begin
`ifdef LOADER_TERMINATOR_EN
                  state_d = StTerm;
                  we_d    = 1'b1;
                  addr_d  = BASE_ADDR + 12'd2 + nrows_q[11:0];
                  data_d  = TERMINATOR;
`else
                  state_d = StFin;
`endif
               end else begin
                  state_d = StFill;
               end
            end
`ifdef LOADER_TERMINATOR_EN
            StTerm: begin
               state_d = StFin;
            end
`endif
            StFin: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_b) begin
         state_q <= StIdle;
         nrows_q <= 16'd0;
         ncols_q <= 16'd0;
         col_q   <= 4'd0;
         row_q   <= 16'd0;
         pack_q  <= 16'd0;
         we_q    <= 1'b0;
         addr_q  <= 12'd0;
         data_q  <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nrows_q <= nrows_d;
         ncols_q <= ncols_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pack_q  <= pack_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_sram_image_loader.sv
// Directed, table-driven bench for sram_image_loader.
module tb_sram_image_loader;

`ifdef LOADER_TERMINATOR_EN
   localparam logic [11:0] Base      = 12'h010;
   localparam int          TermWords = 1;
`else
   localparam logic [11:0] Base      = 12'h000;
   localparam int          TermWords = 0;
`endif
   localparam logic [15:0] Term = 16'h00FF;

   logic        clk;
   logic        reset_b;
   logic        load_start;
   logic [15:0] load_nrows;
   logic [15:0] load_ncols;
   logic        load_abort;
   logic        pix_valid;
   logic        pix_data;
   logic        pix_ready;
   logic        loader_busy;
   logic        load_done;
   logic        load_error;
   logic [11:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_en;

   sram_image_loader #(
      .BASE_ADDR (Base),
      .MAX_ROWS  (16),
      .TERMINATOR(Term)
   ) dut (
      .clk                   (clk),
      .reset_b               (reset_b),
      .load_start            (load_start),
      .load_nrows            (load_nrows),
      .load_ncols            (load_ncols),
      .load_abort            (load_abort),
      .pix_valid             (pix_valid),
      .pix_data              (pix_data),
      .pix_ready             (pix_ready),
      .loader_busy           (loader_busy),
      .load_done             (load_done),
      .load_error            (load_error),
      .dut_sram_write_address(wr_addr),
      .dut_sram_write_data   (wr_data),
      .dut_sram_write_enable (wr_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // beats[r][15-c] is the c-th beat of row r; exp[r] is the hand-packed word.
   typedef struct packed {
      logic [15:0]      nrows;
      logic [15:0]      ncols;
      logic [3:0][15:0] beats;
      logic [3:0][15:0] exp;
      logic             stall;
      logic             exp_err;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int cyc = 0, last_we_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, overlap = 0;
   logic [27:0] wr_q[$];
   bit tog = 1'b0;
   vec_t vecs[10];

   always @(negedge clk) begin
      cyc++;
      if (wr_en) begin
         wr_q.push_back({wr_addr, wr_data});
         last_we_cyc = cyc;
      end
      if (load_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (load_error) err_cnt++;
      if (wr_en && pix_ready) overlap++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] nr, input logic [15:0] nc,
                               input logic [15:0] b0, input logic [15:0] b1,
                               input logic [15:0] b2, input logic [15:0] b3,
                               input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3,
                               input logic st, input logic er);
      vec_t v;
      v.nrows = nr;  v.ncols = nc;
      v.beats = {b3, b2, b1, b0};
      v.exp   = {e3, e2, e1, e0};
      v.stall = st;  v.exp_err = er;
      return v;
   endfunction

   task automatic clear_mon();
      wr_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic pulse_start(input logic [15:0] nr, input logic [15:0] nc);
      load_nrows = nr;
      load_ncols = nc;
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   // Offers one beat until it transfers; with stall set, valid drops every other cycle.
   task automatic feed_beat(input logic b, input logic stall);
      int  n = 0;
      bit  taken = 1'b0;
      while (!taken && n < 64) begin
         pix_valid = stall ? tog : 1'b1;
         pix_data  = b;
         tog       = ~tog;
         @(negedge clk);
         taken = pix_valid && pix_ready;
         @(posedge clk); #1;
         n++;
      end
      pix_valid = 1'b0;
      if (!taken) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout: got no transfer required transfer within 64 cycles");
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v, input int vi);
      int          nwr;
      logic [15:0] ed;
      clear_mon();
      pulse_start(v.nrows, v.ncols);
      if (v.exp_err) begin
         @(negedge clk);
         check($sformatf("v%0d_err_pulse", vi), 32'(load_error), 32'd1);
         check($sformatf("v%0d_err_busy", vi), 32'(loader_busy), 32'd0);
         repeat (4) @(posedge clk);
         #1;
         check($sformatf("v%0d_err_cnt", vi), 32'(err_cnt), 32'd1);
         check($sformatf("v%0d_err_writes", vi), 32'(wr_q.size()), 32'd0);
      end else begin
         for (int r = 0; r < int'(v.nrows); r++)
            for (int c = 0; c < int'(v.ncols); c++)
               feed_beat(v.beats[r % 4][15 - c], v.stall);
         wait_done();
         nwr = int'(v.nrows) + 2 + TermWords;
         check($sformatf("v%0d_nwrites", vi), 32'(wr_q.size()), 32'(nwr));
         for (int i = 0; i < nwr && i < wr_q.size(); i++) begin
            if (i == 0) ed = v.nrows;
            else if (i == 1) ed = v.ncols;
            else if (i < int'(v.nrows) + 2) ed = v.exp[(i - 2) % 4];
            else ed = Term;
            check($sformatf("v%0d_wr%0d", vi, i), 32'(wr_q[i]), 32'({Base + 12'(i), ed}));
         end
         check($sformatf("v%0d_done_cnt", vi), 32'(done_cnt), 32'd1);
         check($sformatf("v%0d_done_lat", vi), 32'(done_cyc - last_we_cyc), 32'd1);
         check($sformatf("v%0d_busy_end", vi), 32'(loader_busy), 32'd0);
      end
   endtask

   initial begin
      reset_b = 1'b1;  load_start = 1'b0;  load_nrows = '0;  load_ncols = '0;
      load_abort = 1'b0;  pix_valid = 1'b0;  pix_data = 1'b0;

      vecs[0] = mk(3, 4, 16'hB000, 16'h1000, 16'hF000, 0, 16'h000D, 16'h0008, 16'h000F, 0, 0, 0);
      vecs[1] = mk(2, 16, 16'hAAAA, 16'hAAAA, 0, 0, 16'h5555, 16'h5555, 0, 0, 1, 0);
      vecs[2] = mk(1, 2, 16'hC000, 0, 0, 0, 16'h0003, 0, 0, 0, 0, 0);
      vecs[3] = mk(2, 1, 16'h8000, 16'h0000, 0, 0, 16'h0001, 16'h0000, 0, 0, 0, 0);
      vecs[4] = mk(1, 5, 16'h6800, 0, 0, 0, 16'h0016, 0, 0, 0, 1, 0);
      vecs[5] = mk(16, 1, 16'h8000, 0, 16'h8000, 0, 16'h0001, 0, 16'h0001, 0, 0, 0);
      vecs[6] = mk(1, 17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[7] = mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[8] = mk(17, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[9] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", {pix_ready, loader_busy, load_done, load_error, wr_en}, 32'd0);
      check("rst_addr_data", {wr_addr, wr_data}, 32'd0);
      @(posedge clk); #1;
      reset_b = 1'b0;

      // Reset in the middle of a row, then a clean reload.
      clear_mon();
      pulse_start(3, 4);
      feed_beat(1'b1, 1'b0);
      feed_beat(1'b0, 1'b0);
      reset_b = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_outputs", {pix_ready, loader_busy, load_done, load_error, wr_en}, 32'd0);
      check("midrst_addr_data", {wr_addr, wr_data}, 32'd0);
      @(posedge clk); #1;
      reset_b = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Start while busy is ignored; abort plus start after the row-1 write.
      clear_mon();
      pulse_start(4, 3);
      pulse_start(1, 2);
      for (int r = 0; r < 2; r++) begin
         feed_beat(1'b1, 1'b0);
         feed_beat(1'b0, 1'b0);
         feed_beat(1'b1, 1'b0);
      end
      @(posedge clk); #1;
      load_abort = 1'b1;  load_start = 1'b1;  load_nrows = 1;  load_ncols = 1;
      @(posedge clk); #1;
      load_abort = 1'b0;  load_start = 1'b0;
      @(negedge clk);
      check("abort_idle", {loader_busy, pix_ready, wr_en}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("abort_nwrites", 32'(wr_q.size()), 32'd4);
      if (wr_q.size() >= 4) begin
         check("abort_hdr_r", 32'(wr_q[0]), 32'({Base, 16'd4}));
         check("abort_hdr_c", 32'(wr_q[1]), 32'({Base + 12'd1, 16'd3}));
         check("abort_row1", 32'(wr_q[3]), 32'({Base + 12'd3, 16'h0005}));
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_no_err", 32'(err_cnt), 32'd0);
      check("abort_busy", 32'(loader_busy), 32'd0);

      // Abort in idle does nothing; a following load still completes.
      load_abort = 1'b1;
      @(posedge clk); #1;
      load_abort = 1'b0;
      run_vec(vecs[2], 10);

      check("ready_during_write", 32'(overlap), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
